// File: rtl/branch_resolve.sv
// Execute-stage branch resolution with a bimodal BHT of 2-bit saturating
// counters. Fetch reads the BHT combinationally. A mispredict in EX produces a
// one-cycle registered redirect/flush at the next edge.
module branch_resolve #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pred_pc_i,
  output logic             pred_taken_o,
  input  logic             ex_valid_i,
  input  logic             ex_is_br_i,
  input  logic [2:0]       ex_funct3_i,
  input  logic [31:0]      ex_pc_i,
  input  logic [31:0]      ex_target_i,
  input  logic             ex_pred_taken_i,
  input  logic             stall_i,
  output logic             br_un_o,
  input  logic             br_eq_i,
  input  logic             br_lt_i,
  output logic             redirect_o,
  output logic [31:0]      redirect_pc_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] br_count_o,
  output logic [CNT_W-1:0] mispred_count_o
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       ex_cnt;
  logic [1:0]       bht_d;

  logic             legal;
  logic             taken;
  logic             res;
  logic             mis;

  logic             redirect_q;
  logic             flush_q;
  logic [31:0]      redirect_pc_q;
  logic [31:0]      redirect_pc_d;
  logic [CNT_W-1:0] br_count_q;
  logic [CNT_W-1:0] mispred_count_q;

  // PC bits outside the word-aligned index field do not address the BHT
  logic unused_pred_pc;
  assign unused_pred_pc = ^{pred_pc_i[31:IDX_W+2], pred_pc_i[1:0]};

  assign pred_idx     = pred_pc_i[IDX_W+1:2];
  assign ex_idx       = ex_pc_i[IDX_W+1:2];
  assign pred_taken_o = bht_q[pred_idx][1];
  assign ex_cnt       = bht_q[ex_idx];
  assign br_un_o      = ex_funct3_i[1];

  // Branch condition decode from the comparator flags
  always_comb begin
    legal = 1'b1;
    taken = 1'b0;
    case (ex_funct3_i)
      3'b000:  taken = br_eq_i;
      3'b001:  taken = ~br_eq_i;
      3'b100:  taken = br_lt_i;
      3'b101:  taken = ~br_lt_i;
      3'b110:  taken = br_lt_i;
      3'b111:  taken = ~br_lt_i;
      default: legal = 1'b0;
    endcase
  end

  // A branch in EX while a redirect is out is on the wrong path and is ignored
  assign res = ex_valid_i & ex_is_br_i & ~stall_i & ~redirect_q & legal;
  assign mis = res & (taken != ex_pred_taken_i);

  // Corrected PC and saturating counter next value
  always_comb begin
    redirect_pc_d = redirect_pc_q;
    if (mis) begin
      redirect_pc_d = taken ? ex_target_i : ex_pc_i + 32'd4;
    end
    bht_d = ex_cnt;
    if (taken) begin
      if (ex_cnt != 2'b11) bht_d = ex_cnt + 2'b01;
    end else begin
      if (ex_cnt != 2'b00) bht_d = ex_cnt - 2'b01;
    end
  end

  // Redirect/flush pulse, redirect PC and performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redirect_q      <= 1'b0;
      flush_q         <= 1'b0;
      redirect_pc_q   <= '0;
      br_count_q      <= '0;
      mispred_count_q <= '0;
    end else begin
      redirect_q      <= mis;
      flush_q         <= mis;
      redirect_pc_q   <= redirect_pc_d;
      br_count_q      <= br_count_q + {{(CNT_W-1){1'b0}}, res};
      mispred_count_q <= mispred_count_q + {{(CNT_W-1){1'b0}}, mis};
    end
  end

  // BHT training on resolved branches; reset to weakly not-taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else if (res) begin
      bht_q[ex_idx] <= bht_d;
    end
  end

  assign redirect_o      = redirect_q;
  assign flush_o         = flush_q;
  assign redirect_pc_o   = redirect_pc_q;
  assign br_count_o      = br_count_q;
  assign mispred_count_o = mispred_count_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Scoreboard bench for branch_resolve: a behavioural model computes the
// expected registered outputs per cycle, queues them, and they are compared
// one cycle later after the clock edge.
module tb_branch_resolve;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pred_pc_i;
  logic        pred_taken_o;
  logic        ex_valid_i;
  logic        ex_is_br_i;
  logic [2:0]  ex_funct3_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_target_i;
  logic        ex_pred_taken_i;
  logic        stall_i;
  logic        br_un_o;
  logic        br_eq_i;
  logic        br_lt_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        flush_o;
  logic [31:0] br_count_o;
  logic [31:0] mispred_count_o;

  always #5 clk_i = ~clk_i;

  branch_resolve #(.BHT_ENTRIES(64), .CNT_W(32)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .pred_pc_i       (pred_pc_i),
    .pred_taken_o    (pred_taken_o),
    .ex_valid_i      (ex_valid_i),
    .ex_is_br_i      (ex_is_br_i),
    .ex_funct3_i     (ex_funct3_i),
    .ex_pc_i         (ex_pc_i),
    .ex_target_i     (ex_target_i),
    .ex_pred_taken_i (ex_pred_taken_i),
    .stall_i         (stall_i),
    .br_un_o         (br_un_o),
    .br_eq_i         (br_eq_i),
    .br_lt_i         (br_lt_i),
    .redirect_o      (redirect_o),
    .redirect_pc_o   (redirect_pc_o),
    .flush_o         (flush_o),
    .br_count_o      (br_count_o),
    .mispred_count_o (mispred_count_o)
  );

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] brc;
    logic [31:0] misc;
  } exp_t;

  exp_t sb_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // model state
  logic [1:0]  m_bht [64];
  logic        m_redir;
  logic [31:0] m_rpc;
  logic [31:0] m_brc;
  logic [31:0] m_misc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: combinational checks and model step before the edge,
  // registered checks after it.
  task automatic cycle();
    exp_t e;
    logic t, legal, res, mis;
    int unsigned ix;
    @(negedge clk_i);
    check_eq("br_un", {31'd0, br_un_o}, {31'd0, ex_funct3_i[1]});
    check_eq("pred_taken", {31'd0, pred_taken_o}, {31'd0, m_bht[pred_pc_i[7:2]][1]});
    legal = (ex_funct3_i[2:1] != 2'b01);
    t = (ex_funct3_i[2] ? br_lt_i : br_eq_i) ^ ex_funct3_i[0];
    res = ex_valid_i && ex_is_br_i && !stall_i && !m_redir && legal;
    mis = res && (t != ex_pred_taken_i);
    if (rst_i) begin
      for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
      m_redir = 1'b0;
      m_rpc   = 32'd0;
      m_brc   = 32'd0;
      m_misc  = 32'd0;
    end else begin
      ix = int'(ex_pc_i[7:2]);
      if (res) begin
        if (t && m_bht[ix] < 2'd3) m_bht[ix] = m_bht[ix] + 2'd1;
        else if (!t && m_bht[ix] > 2'd0) m_bht[ix] = m_bht[ix] - 2'd1;
      end
      if (mis) m_rpc = t ? ex_target_i : ex_pc_i + 32'd4;
      m_redir = mis;
      m_brc   = m_brc + (res ? 32'd1 : 32'd0);
      m_misc  = m_misc + (mis ? 32'd1 : 32'd0);
    end
    e.redir = m_redir;
    e.rpc   = m_rpc;
    e.brc   = m_brc;
    e.misc  = m_misc;
    sb_q.push_back(e);
    @(posedge clk_i);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_eq("redirect", {31'd0, redirect_o}, {31'd0, e.redir});
      check_eq("flush", {31'd0, flush_o}, {31'd0, e.redir});
      check_eq("redirect_pc", redirect_pc_o, e.rpc);
      check_eq("br_count", br_count_o, e.brc);
      check_eq("mispred_count", mispred_count_o, e.misc);
    end
  endtask

  task automatic set_br(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] tgt,
                        input logic eq, input logic lt, input logic pred);
    ex_valid_i      = 1'b1;
    ex_is_br_i      = 1'b1;
    ex_funct3_i     = f3;
    ex_pc_i         = pc;
    ex_target_i     = tgt;
    br_eq_i         = eq;
    br_lt_i         = lt;
    ex_pred_taken_i = pred;
  endtask

  task automatic idle();
    ex_valid_i = 1'b0;
    ex_is_br_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_bht[i] = 2'bxx;
    m_redir = 1'b0;
    m_rpc   = 32'd0;
    m_brc   = 32'd0;
    m_misc  = 32'd0;
    rst_i = 1'b1;
    pred_pc_i = 32'h0000_0100;
    stall_i = 1'b0;
    set_br(32'd0, 3'b000, 32'd0, 1'b0, 1'b0, 1'b0);
    idle();
    // model BHT starts unknown; the first (reset) cycle skips its BHT check
    @(negedge clk_i);
    for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cycle();
    check_eq("rst_pred", {31'd0, pred_taken_o}, 32'd0);
    check_eq("rst_brc", br_count_o, 32'd0);

    // BEQ taken, predicted not-taken
    set_br(32'h0000_0100, 3'b000, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
    cycle();
    check_eq("beq_redir", {31'd0, redirect_o}, 32'd1);
    check_eq("beq_rpc", redirect_pc_o, 32'h0000_0080);
    idle();
    cycle();
    check_eq("beq_pulse_end", {31'd0, redirect_o}, 32'd0);
    check_eq("beq_bht_msb", {31'd0, pred_taken_o}, 32'd1);

    // BLTU not taken at top of address space, predicted taken: pc+4 wraps
    set_br(32'hFFFF_FFFC, 3'b110, 32'h0000_0010, 1'b0, 1'b0, 1'b1);
    cycle();
    check_eq("bltu_rpc_wrap", redirect_pc_o, 32'h0000_0000);
    check_eq("bltu_misc", mispred_count_o, 32'd2);
    idle();
    cycle();

    // four correctly predicted taken BNE: counter saturates
    pred_pc_i = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      set_br(32'h0000_0200, 3'b001, 32'h0000_0300, 1'b0, 1'b0, 1'b1);
      cycle();
      check_eq("bne_no_redir", {31'd0, redirect_o}, 32'd0);
    end
    idle();
    cycle();
    check_eq("bne_pred", {31'd0, pred_taken_o}, 32'd1);
    check_eq("bne_brc", br_count_o, 32'd6);

    // mispredict, then a wrong-path branch in EX during the redirect
    pred_pc_i = 32'h0000_0404;
    set_br(32'h0000_0400, 3'b000, 32'h0000_0500, 1'b1, 1'b0, 1'b0);
    cycle();
    set_br(32'h0000_0404, 3'b000, 32'h0000_0600, 1'b1, 1'b0, 1'b0);
    cycle();
    check_eq("wrongpath_ignored", {31'd0, redirect_o}, 32'd0);
    check_eq("wrongpath_brc", br_count_o, 32'd7);
    idle();
    cycle();

    // stalled branch resolves exactly once on release
    set_br(32'h0000_0408, 3'b100, 32'h0000_0700, 1'b0, 1'b1, 1'b0);
    stall_i = 1'b1;
    repeat (3) cycle();
    stall_i = 1'b0;
    cycle();
    check_eq("stall_release_rpc", redirect_pc_o, 32'h0000_0700);
    idle();
    cycle();
    check_eq("stall_brc", br_count_o, 32'd8);

    // reserved funct3 encodings are ignored
    set_br(32'h0000_0500, 3'b010, 32'h0000_0900, 1'b1, 1'b1, 1'b0);
    cycle();
    set_br(32'h0000_0500, 3'b011, 32'h0000_0900, 1'b1, 1'b1, 1'b0);
    cycle();
    check_eq("illegal_brc", br_count_o, 32'd8);
    idle();
    cycle();

    // mispredict pulse, then reset clears it and the BHT
    pred_pc_i = 32'h0000_0100;
    set_br(32'h0000_0100, 3'b000, 32'h0000_0080, 1'b0, 1'b0, 1'b1);
    cycle();
    rst_i = 1'b1;
    cycle();
    check_eq("rst_after_mis", {31'd0, redirect_o}, 32'd0);
    // reset coincident with a mispredict in EX: no pulse follows
    set_br(32'h0000_0100, 3'b000, 32'h0000_0080, 1'b1, 1'b0, 1'b0);
    cycle();
    rst_i = 1'b0;
    idle();
    cycle();
    check_eq("rst_discard_mis", {31'd0, redirect_o}, 32'd0);
    check_eq("rst_bht", {31'd0, pred_taken_o}, 32'd0);

    // random traffic on a small PC window to exercise BHT aliasing
    for (int k = 0; k < 400; k++) begin
      rst_i           = ($urandom_range(0, 59) == 0);
      ex_valid_i      = ($urandom_range(0, 9) != 0);
      ex_is_br_i      = ($urandom_range(0, 5) != 0);
      ex_funct3_i     = 3'($urandom_range(0, 7));
      ex_pc_i         = {$urandom_range(0, 3) == 0 ? 24'hFFFFFF : 24'h0, 6'($urandom_range(0, 15)), 2'b00};
      ex_target_i     = $urandom;
      br_eq_i         = 1'($urandom_range(0, 1));
      br_lt_i         = 1'($urandom_range(0, 1));
      ex_pred_taken_i = 1'($urandom_range(0, 1));
      stall_i         = ($urandom_range(0, 3) == 0);
      pred_pc_i       = {24'h0, 6'($urandom_range(0, 15)), 2'b00};
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
